// File: rtl/button_toggle_bank.sv
// button_toggle_bank: per-channel debounce, press strobe and toggle/momentary output.
// Optional BUTTON_SYNC_EN inserts a 2-flop synchroniser ahead of each debouncer.
module button_toggle_bank #(
    parameter int CHANNELS        = 4,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] button,
    input  logic [CHANNELS-1:0] mode,
    input  logic                clear,
    output logic [CHANNELS-1:0] stateful_button,
    output logic [CHANNELS-1:0] press_pulse
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CHANNELS-1:0] s;
    logic [CHANNELS-1:0] db;
    logic [CHANNELS-1:0] tgl;
    logic [CHANNELS-1:0] accept;
    logic [CHANNELS-1:0] press;
    logic [CW-1:0]       cnt [CHANNELS];

`ifdef BUTTON_SYNC_EN
    logic [CHANNELS-1:0] sync1;
    logic [CHANNELS-1:0] sync2;
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= button;
            sync2 <= sync1;
        end
    end
    assign s = sync2;
`else
    assign s = button;
`endif

    always_comb begin
        accept = '0;
        press  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            accept[i] = (s[i] != db[i]) && (cnt[i] == LAST);
            press[i]  = accept[i] && s[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            db          <= '0;
            tgl         <= '0;
            press_pulse <= '0;
            for (int i = 0; i < CHANNELS; i++) cnt[i] <= '0;
        end else begin
            press_pulse <= press;
            // clear has priority over a coincident press on the toggle state
            tgl         <= clear ? '0 : tgl ^ press;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt[i] <= (s[i] == db[i] || accept[i]) ? '0 : cnt[i] + 1'b1;
                if (accept[i]) db[i] <= s[i];
            end
        end
    end

    assign stateful_button = (mode & db) | (~mode & tgl);
endmodule

// File: tb/tb_button_toggle_bank.sv
// tb_button_toggle_bank: directed and randomized checks against a streak-based reference model.
module tb_button_toggle_bank;
    localparam int N = 4;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [N-1:0] button = '0;
    logic [N-1:0] mode = '0;
    logic         clear = 1'b0;
    logic [N-1:0] stateful_button;
    logic [N-1:0] press_pulse;

    int checks = 0;
    int failures = 0;

    int       streak [N];
    bit       last [N];
    bit [N-1:0] m_db, m_tgl, m_pulse;

    button_toggle_bank #(.CHANNELS(N), .DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .reset(reset), .button(button), .mode(mode), .clear(clear),
        .stateful_button(stateful_button), .press_pulse(press_pulse)
    );

    always #5 clk = ~clk;

    // A level is accepted once the most recent D samples all differ from the accepted level.
    task automatic model(input logic [N-1:0] b, input logic c, input logic r);
        if (r) begin
            m_db = '0; m_tgl = '0; m_pulse = '0;
            for (int i = 0; i < N; i++) begin streak[i] = 0; last[i] = 1'b0; end
        end else begin
            for (int i = 0; i < N; i++) begin
                bit acc;
                streak[i] = (streak[i] > 0 && b[i] == last[i]) ? streak[i] + 1 : 1;
                last[i] = b[i];
                acc = (b[i] != m_db[i]) && (streak[i] >= D);
                m_pulse[i] = acc && b[i];
                if (acc) m_db[i] = b[i];
                if (c) m_tgl[i] = 1'b0;
                else if (m_pulse[i]) m_tgl[i] = ~m_tgl[i];
            end
        end
    endtask

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [N-1:0] b, input logic [N-1:0] m, input logic c, input logic r);
        button = b; mode = m; clear = c; reset = r;
        @(posedge clk);
        model(b, c, r);
        @(negedge clk);
        chk("model_sb", stateful_button, (mode & m_db) | (~mode & m_tgl));
        chk("model_pp", press_pulse, m_pulse);
    endtask

    initial begin
        logic [N-1:0] rb, rm;
        // reset with all buttons held
        step(4'b1111, 4'b0000, 1'b0, 1'b1);
        step(4'b1111, 4'b0000, 1'b0, 1'b1);
        chk("reset_sb", stateful_button, 4'b0000);
        chk("reset_pp", press_pulse, 4'b0000);
        step(4'b0000, 4'b0000, 1'b0, 1'b0);
        // clean press on ch0
        repeat (3) step(4'b0001, 4'b0000, 1'b0, 1'b0);
        chk("clean_early_pp", press_pulse, 4'b0000);
        step(4'b0001, 4'b0000, 1'b0, 1'b0);
        chk("clean_pp", press_pulse, 4'b0001);
        chk("clean_sb", stateful_button, 4'b0001);
        step(4'b0001, 4'b0000, 1'b0, 1'b0);
        chk("clean_pp_once", press_pulse, 4'b0000);
        repeat (4) step(4'b0000, 4'b0000, 1'b0, 1'b0);
        repeat (4) step(4'b0001, 4'b0000, 1'b0, 1'b0);
        chk("second_pp", press_pulse, 4'b0001);
        chk("second_sb", stateful_button, 4'b0000);
        repeat (4) step(4'b0000, 4'b0000, 1'b0, 1'b0);
        // bouncing ch1
        foreach (rb[i]) rb[i] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            logic [7:0] pat;
            pat = 8'b1011_0111;
            step({2'b00, pat[7-k], 1'b0}, 4'b0000, 1'b0, 1'b0);
            chk("bounce_nopulse", press_pulse, 4'b0000);
        end
        step(4'b0010, 4'b0000, 1'b0, 1'b0);
        chk("bounce_pp", press_pulse, 4'b0010);
        chk("bounce_sb", stateful_button, 4'b0010);
        repeat (4) step(4'b0000, 4'b0000, 1'b0, 1'b0);
        // momentary ch2
        repeat (4) step(4'b0100, 4'b0100, 1'b0, 1'b0);
        chk("mom_hi_sb", stateful_button, 4'b0110);
        repeat (4) step(4'b0000, 4'b0100, 1'b0, 1'b0);
        chk("mom_lo_sb", stateful_button, 4'b0010);
        step(4'b0000, 4'b0000, 1'b0, 1'b0);
        chk("mom_switch_sb", stateful_button, 4'b0110);
        // clear colliding with ch3 press
        repeat (3) step(4'b1000, 4'b0000, 1'b0, 1'b0);
        step(4'b1000, 4'b0000, 1'b1, 1'b0);
        chk("clear_pp", press_pulse, 4'b1000);
        chk("clear_sb", stateful_button, 4'b0000);
        repeat (4) step(4'b0000, 4'b0000, 1'b0, 1'b0);
        // reset mid-count
        repeat (3) step(4'b0001, 4'b0000, 1'b0, 1'b0);
        step(4'b0001, 4'b0000, 1'b0, 1'b1);
        step(4'b0001, 4'b0000, 1'b0, 1'b0);
        chk("midcount_pp", press_pulse, 4'b0000);
        chk("midcount_sb", stateful_button, 4'b0000);
        // randomized traffic: held levels with occasional bounces, mode flips, clears, resets
        rb = '0; rm = '0;
        for (int k = 0; k < 600; k++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 5) == 0) rb[i] = ~rb[i];
            if ($urandom_range(0, 19) == 0) rm = 4'($urandom);
            step(rb, rm, $urandom_range(0, 24) == 0, $urandom_range(0, 99) == 0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
